// File: rtl/eei.sv
// Shared definitions for the memory-bus arbiter slice.
//   Addr               : memory address type
//   MEM_DATA_WIDTH     : data width of every membus port
//   STARVE_MAX_DEFAULT : default number of data grants a waiting fetch tolerates
//   Owner              : which requester owns the shared port
//   arb_state_e        : arbiter FSM states, exported for debug visibility
package eei;
  typedef logic [31:0] Addr;

  localparam int MEM_DATA_WIDTH     = 32;
  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    None  = 2'd0,
    Fetch = 2'd1,
    Data  = 2'd2
  } Owner;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } arb_state_e;
endpackage

// File: rtl/membus_if.sv
// Memory bus interface.
// Handshake: a request transfers on a cycle where valid=1 and ready=1;
// the requester holds valid/addr/wen/wdata/wmask stable until then.
// A response is a single cycle with rvalid=1 carrying rdata; it has no
// back-pressure.
//   master : drives the request, receives ready and the response
//   slave  : receives the request, drives ready and the response
interface membus_if;
  import eei::*;

  logic                          valid;
  logic                          ready;
  Addr                           addr;
  logic                          wen;
  logic [MEM_DATA_WIDTH-1:0]     wdata;
  logic [MEM_DATA_WIDTH/8-1:0]   wmask;
  logic                          rvalid;
  logic [MEM_DATA_WIDTH-1:0]     rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/membus_arb_sel.sv
// Combinational winner selection between fetch and data requesters.
//   ivalid     : fetch requester valid
//   dvalid     : data requester valid
//   starve_cnt : consecutive data grants taken while fetch waited
//   winner     : selected owner (None when nobody requests)
// Data is preferred; once the fetch side has waited STARVE_MAX data
// grants it wins the next contended cycle.
module membus_arb_sel
  import eei::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic       ivalid,
  input  logic       dvalid,
  input  logic [3:0] starve_cnt,
  output Owner       winner
);

  always_comb begin
    winner = None;
    if (ivalid && dvalid) begin
      winner = (starve_cnt == 4'(STARVE_MAX)) ? Fetch : Data;
    end else if (dvalid) begin
      winner = Data;
    end else if (ivalid) begin
      winner = Fetch;
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Two-requester arbiter for a single shared memory port.
//   clk            : clock
//   rst            : asynchronous active-low reset
//   ibus           : instruction-fetch requester
//   dbus           : data requester
//   mbus           : shared memory port
//   grant          : one-hot owner (bit0 fetch, bit1 data, 0 none)
//   dbg_state      : FSM state, for observation only
//   dbg_starve_cnt : starvation counter, for observation only
// One transaction is outstanding at a time. In Idle the winner is routed
// to mbus in the same cycle, so arbitration adds no request latency.
module membus_arbiter
  import eei::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  membus_if.slave     ibus,
  membus_if.slave     dbus,
  membus_if.master    mbus,
  output logic [1:0]  grant,
  output arb_state_e  dbg_state,
  output logic [3:0]  dbg_starve_cnt
);

  arb_state_e state;
  Owner       owner;
  logic [3:0] starve_cnt;
  Owner       winner;
  Owner       sel;
  logic       req_phase;

  membus_arb_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .ivalid     (ibus.valid),
    .dvalid     (dbus.valid),
    .starve_cnt (starve_cnt),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= None;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (winner != None) begin
            owner <= winner;
            state <= mbus.ready ? ST_WAIT_RESP : ST_ISSUE;
            // Only a data grant that actually bypassed a waiting fetch counts.
            if (winner == Data && ibus.valid) begin
              starve_cnt <= (starve_cnt == 4'(STARVE_MAX)) ? starve_cnt
                                                            : starve_cnt + 4'd1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (mbus.ready) begin
            state <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (mbus.rvalid) begin
            state <= ST_IDLE;
            owner <= None;
          end
        end
        default: begin
          state <= ST_IDLE;
          owner <= None;
        end
      endcase
    end
  end

  // Idle routes the fresh winner; afterwards only the latched owner counts,
  // even if that port drops valid or the other port starts requesting.
  always_comb begin
    sel       = (state == ST_IDLE) ? winner : owner;
    req_phase = rst && (state != ST_WAIT_RESP);

    mbus.valid = 1'b0;
    mbus.addr  = '0;
    mbus.wen   = 1'b0;
    mbus.wdata = '0;
    mbus.wmask = '0;
    ibus.ready = 1'b0;
    dbus.ready = 1'b0;

    if (req_phase) begin
      case (sel)
        Fetch: begin
          mbus.valid = ibus.valid;
          mbus.addr  = ibus.addr;
          mbus.wen   = ibus.wen;
          mbus.wdata = ibus.wdata;
          mbus.wmask = ibus.wmask;
          ibus.ready = mbus.ready;
        end
        Data: begin
          mbus.valid = dbus.valid;
          mbus.addr  = dbus.addr;
          mbus.wen   = dbus.wen;
          mbus.wdata = dbus.wdata;
          mbus.wmask = dbus.wmask;
          dbus.ready = mbus.ready;
        end
        default: ;
      endcase
    end

    // Responses are only meaningful while waiting for one; anything else
    // (including a late reply to a request killed by reset) is dropped.
    ibus.rvalid = rst && (state == ST_WAIT_RESP) && (owner == Fetch) && mbus.rvalid;
    dbus.rvalid = rst && (state == ST_WAIT_RESP) && (owner == Data) && mbus.rvalid;
    ibus.rdata  = mbus.rdata;
    dbus.rdata  = mbus.rdata;

    grant = 2'b00;
    if (rst) begin
      case (sel)
        Fetch:   grant = 2'b01;
        Data:    grant = 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: inputs change 1 time unit after the
// rising edge, outputs are checked 1 unit later, well away from any edge.
module tb_membus_arbiter;
  import eei::*;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  arb_state_e dbg_state;
  logic [3:0] dbg_starve_cnt;

  int checks;
  int errors;

  membus_if ib ();
  membus_if db ();
  membus_if mb ();

  membus_arbiter #(
    .STARVE_MAX (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ibus           (ib),
    .dbus           (db),
    .mbus           (mb),
    .grant          (grant),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ib.valid = 1'b0; ib.addr = '0; ib.wen = 1'b0; ib.wdata = '0; ib.wmask = '0;
    db.valid = 1'b0; db.addr = '0; db.wen = 1'b0; db.wdata = '0; db.wmask = '0;
    mb.ready = 1'b0; mb.rvalid = 1'b0; mb.rdata = '0;
  endtask

  initial begin
    logic [1:0] exp_grant [5];
    logic [3:0] exp_cnt   [5];
    exp_grant = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    exp_cnt   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    checks = 0;
    errors = 0;

    // reset with activity on every input: nothing may leak out
    rst = 1'b0;
    idle_inputs();
    ib.valid = 1'b1; ib.addr = 32'h4000;
    mb.ready = 1'b1; mb.rvalid = 1'b1;
    #3;
    chk("rst_mvalid", mb.valid, 1'b0);
    chk("rst_iready", ib.ready, 1'b0);
    chk("rst_dready", db.ready, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_irvalid", ib.rvalid, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_cnt", dbg_starve_cnt, 4'd0);
    cyc();
    idle_inputs();
    rst = 1'b1;
    cyc();

    // data read, ready on grant cycle, response two cycles later
    db.valid = 1'b1; db.addr = 32'h1000; db.wen = 1'b0;
    mb.ready = 1'b1;
    #1;
    chk("rd_mvalid", mb.valid, 1'b1);
    chk("rd_maddr", mb.addr, 32'h1000);
    chk("rd_mwen", mb.wen, 1'b0);
    chk("rd_dready", db.ready, 1'b1);
    chk("rd_iready", ib.ready, 1'b0);
    chk("rd_grant0", grant, 2'b10);
    cyc();
    db.valid = 1'b0; mb.ready = 1'b0;
    #1;
    chk("rd_state1", dbg_state, ST_WAIT_RESP);
    chk("rd_grant1", grant, 2'b10);
    chk("rd_mvalid1", mb.valid, 1'b0);
    cyc();
    mb.rvalid = 1'b1; mb.rdata = 32'hDEADBEEF;
    #1;
    chk("rd_drvalid", db.rvalid, 1'b1);
    chk("rd_drdata", db.rdata, 32'hDEADBEEF);
    chk("rd_irvalid", ib.rvalid, 1'b0);
    chk("rd_grant2", grant, 2'b10);
    cyc();
    mb.rvalid = 1'b0;
    #1;
    chk("rd_grant3", grant, 2'b00);
    chk("rd_state3", dbg_state, ST_IDLE);
    cyc();

    // data store passes write fields bit-exact on the issue cycle
    db.valid = 1'b1; db.addr = 32'h1004; db.wen = 1'b1;
    db.wdata = 32'h11223344; db.wmask = 4'h0F;
    mb.ready = 1'b1;
    #1;
    chk("st_mvalid", mb.valid, 1'b1);
    chk("st_mwen", mb.wen, 1'b1);
    chk("st_mwmask", mb.wmask, 4'h0F);
    chk("st_mwdata", mb.wdata, 32'h11223344);
    cyc();
    idle_inputs();
    mb.rvalid = 1'b1;
    #1;
    chk("st_state", dbg_state, ST_WAIT_RESP);
    chk("st_drvalid", db.rvalid, 1'b1);
    cyc();
    mb.rvalid = 1'b0;
    #1;
    chk("st_idle", dbg_state, ST_IDLE);
    cyc();

    // both requesting continuously: D,D,D,D then the starved fetch wins
    ib.valid = 1'b1; ib.addr = 32'h2000;
    db.valid = 1'b1; db.addr = 32'h1000; db.wen = 1'b0;
    mb.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("sv_grant%0d", k), grant, exp_grant[k]);
      cyc();
      mb.rvalid = 1'b1;
      #1;
      chk($sformatf("sv_cnt%0d", k), dbg_starve_cnt, exp_cnt[k]);
      chk($sformatf("sv_state%0d", k), dbg_state, ST_WAIT_RESP);
      cyc();
      mb.rvalid = 1'b0;
    end
    idle_inputs();
    #1;
    chk("sv_idle", dbg_state, ST_IDLE);
    cyc();

    // fetch owns the port through a stall; dbus and a stray rvalid are ignored
    ib.valid = 1'b1; ib.addr = 32'h2000;
    mb.ready = 1'b0;
    #1;
    chk("is_grant0", grant, 2'b01);
    chk("is_maddr0", mb.addr, 32'h2000);
    cyc();
    db.valid = 1'b1; db.addr = 32'h3000;
    for (int i = 0; i < 2; i++) begin
      mb.rvalid = (i == 1);
      #1;
      chk($sformatf("is_maddr%0d", i + 1), mb.addr, 32'h2000);
      chk($sformatf("is_dready%0d", i + 1), db.ready, 1'b0);
      chk($sformatf("is_state%0d", i + 1), dbg_state, ST_ISSUE);
      chk($sformatf("is_grant%0d", i + 1), grant, 2'b01);
      chk($sformatf("is_irvalid%0d", i + 1), ib.rvalid, 1'b0);
      cyc();
      mb.rvalid = 1'b0;
    end
    mb.ready = 1'b1;
    #1;
    chk("is_iready", ib.ready, 1'b1);
    chk("is_dready3", db.ready, 1'b0);
    chk("is_maddr3", mb.addr, 32'h2000);
    cyc();
    idle_inputs();
    mb.rvalid = 1'b1; mb.rdata = 32'hCAFE0001;
    #1;
    chk("is_wait", dbg_state, ST_WAIT_RESP);
    chk("is_irvalid", ib.rvalid, 1'b1);
    chk("is_drvalid", db.rvalid, 1'b0);
    cyc();
    mb.rvalid = 1'b0;
    #1;
    chk("is_idle", dbg_state, ST_IDLE);
    cyc();

    // reset while waiting for a response; the late response is dropped
    db.valid = 1'b1; db.addr = 32'h5000;
    mb.ready = 1'b1;
    cyc();
    idle_inputs();
    #1;
    chk("rw_wait", dbg_state, ST_WAIT_RESP);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_state", dbg_state, ST_IDLE);
    chk("rw_grant", grant, 2'b00);
    chk("rw_mvalid", mb.valid, 1'b0);
    cyc();
    rst = 1'b1;
    mb.rvalid = 1'b1; mb.rdata = 32'h0BADF00D;
    #1;
    chk("rw_irvalid", ib.rvalid, 1'b0);
    chk("rw_drvalid", db.rvalid, 1'b0);
    chk("rw_grant2", grant, 2'b00);
    cyc();
    mb.rvalid = 1'b0;
    #1;
    chk("rw_idle", dbg_state, ST_IDLE);
    cyc();

    // stray response in Idle with no request
    mb.rvalid = 1'b1; mb.rdata = 32'h00000055;
    #1;
    chk("sr_irvalid", ib.rvalid, 1'b0);
    chk("sr_drvalid", db.rvalid, 1'b0);
    chk("sr_irdata", ib.rdata, 32'h00000055);
    chk("sr_drdata", db.rdata, 32'h00000055);
    cyc();
    mb.rvalid = 1'b0;
    #1;
    chk("sr_idle", dbg_state, ST_IDLE);
    chk("sr_grant", grant, 2'b00);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
